atm_fsm: RTL and testbench

ATM_FSM -- requirements
Module: atm_fsm

---
 rtl/atm_pkg.sv | 20 ++
 rtl/atm_alu.sv | 53 +++++
 rtl/atm_fsm.sv | 137 +++++++++++++
 tb/tb_atm_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller: state encoding,
// operation codes and the wrong-PIN limit.
package atm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PASSWORD = 2'd1,
    ST_MENU     = 2'd2,
    ST_EXEC     = 2'd3
  } atm_state_t;

  localparam logic [1:0] OP_WITHDRAW = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_INQUIRY  = 2'b10;
  localparam logic [1:0] OP_INVALID  = 2'b11;

  // Attempt count already reached when the next wrong PIN ends the session.
  localparam logic [1:0] LAST_ATTEMPT = 2'd2;

endpackage

// File: rtl/atm_alu.sv
// Combinational transaction arithmetic: new balance and failure flag for
// withdraw, deposit, inquiry and invalid operation codes.
module atm_alu
  import atm_pkg::*;
#(
  parameter int balance_width = 20
) (
  input  logic [1:0]               i_op,
  input  logic [balance_width-1:0] i_value,
  input  logic [balance_width-1:0] i_current_balance,
  output logic [balance_width-1:0] o_result,
  output logic                     o_error
);

  logic [balance_width:0] w_sum;

  assign w_sum = {1'b0, i_current_balance} + {1'b0, i_value};

  // On any failure the result falls back to the untouched account balance.
  always_comb begin
    o_result = i_current_balance;
    o_error  = 1'b0;
    case (i_op)
      OP_WITHDRAW: begin
        if (i_value <= i_current_balance) begin
          o_result = i_current_balance - i_value;
          o_error  = 1'b0;
        end else begin
          o_result = i_current_balance;
          o_error  = 1'b1;
        end
      end
      OP_DEPOSIT: begin
        if (w_sum[balance_width]) begin
          o_result = i_current_balance;
          o_error  = 1'b1;
        end else begin
          o_result = w_sum[balance_width-1:0];
          o_error  = 1'b0;
        end
      end
      OP_INQUIRY: begin
        o_result = i_current_balance;
        o_error  = 1'b0;
      end
      default: begin
        o_result = i_current_balance;
        o_error  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/atm_fsm.sv
// ATM session controller: card/PIN handling, menu selection and transaction
// execution with registered status pulses and timer control.
module atm_fsm
  import atm_pkg::*;
#(
  parameter int balance_width = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     wrong_psw,
  input  logic                     language,
  input  logic [1:0]               operation,
  input  logic [balance_width-1:0] value,
  input  logic [balance_width-1:0] current_balance,
  input  logic                     another_service,
  input  logic                     timeout,
  output logic [balance_width-1:0] balance,
  output logic                     op_done,
  output logic                     error,
  output logic                     start_timer,
  output logic                     restart_timer
);

  atm_state_t               r_state;
  logic [1:0]               r_attempts;
  logic                     r_language;
  logic [1:0]               r_op;
  logic [balance_width-1:0] r_value;
  logic [balance_width-1:0] r_balance;
  logic                     r_op_done;
  logic                     r_error;
  logic                     r_start_timer;
  logic                     r_restart_timer;

  logic [balance_width-1:0] w_alu_result;
  logic                     w_alu_error;

  atm_alu #(.balance_width(balance_width)) u_alu (
    .i_op              (r_op),
    .i_value           (r_value),
    .i_current_balance (current_balance),
    .o_result          (w_alu_result),
    .o_error           (w_alu_error)
  );

  // Session state machine; timeout beats card removal, which beats everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_attempts      <= 2'd0;
      r_language      <= 1'b0;
      r_op            <= 2'b00;
      r_value         <= '0;
      r_balance       <= '0;
      r_op_done       <= 1'b0;
      r_error         <= 1'b0;
      r_start_timer   <= 1'b0;
      r_restart_timer <= 1'b0;
    end else begin
      r_op_done       <= 1'b0;
      r_error         <= 1'b0;
      r_start_timer   <= 1'b0;
      r_restart_timer <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_attempts <= 2'd0;
          if (card_in) begin
            r_state       <= ST_PASSWORD;
            r_start_timer <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (timeout) begin
            r_state    <= ST_IDLE;
            r_error    <= 1'b1;
            r_attempts <= 2'd0;
          end else if (!card_in) begin
            r_state    <= ST_IDLE;
            r_attempts <= 2'd0;
          end else begin
            case (r_state)
              ST_PASSWORD: begin
                if (!wrong_psw) begin
                  r_state         <= ST_MENU;
                  r_language      <= language;
                  r_attempts      <= 2'd0;
                  r_restart_timer <= 1'b1;
                end else if (r_attempts == LAST_ATTEMPT) begin
                  r_state    <= ST_IDLE;
                  r_error    <= 1'b1;
                  r_attempts <= 2'd0;
                end else begin
                  r_state    <= ST_PASSWORD;
                  r_attempts <= r_attempts + 2'd1;
                end
              end
              ST_MENU: begin
                r_op    <= operation;
                r_value <= value;
                r_state <= ST_EXEC;
              end
              ST_EXEC: begin
                // An invalid code leaves the reported balance where it was.
                if (r_op != OP_INVALID) begin
                  r_balance <= w_alu_result;
                end else begin
                  r_balance <= r_balance;
                end
                r_op_done <= ~w_alu_error;
                r_error   <= w_alu_error;
                if (another_service) begin
                  r_state         <= ST_MENU;
                  r_restart_timer <= 1'b1;
                end else begin
                  r_state <= ST_IDLE;
                end
              end
              default: begin
                r_state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign balance       = r_balance;
  assign op_done       = r_op_done;
  assign error         = r_error;
  assign start_timer   = r_start_timer;
  assign restart_timer = r_restart_timer;

endmodule

// File: tb/tb_atm_fsm.sv
// Directed self-checking bench for atm_fsm with hand-computed expectations.
module tb_atm_fsm;
  import atm_pkg::*;

  localparam int BW = 20;

  logic          clk;
  logic          rst;
  logic          card_in;
  logic          wrong_psw;
  logic          language;
  logic [1:0]    operation;
  logic [BW-1:0] value;
  logic [BW-1:0] current_balance;
  logic          another_service;
  logic          timeout;
  logic [BW-1:0] balance;
  logic          op_done;
  logic          error;
  logic          start_timer;
  logic          restart_timer;

  int n_checks;
  int n_fail;

  atm_fsm #(.balance_width(BW)) dut (
    .clk             (clk),
    .rst             (rst),
    .card_in         (card_in),
    .wrong_psw       (wrong_psw),
    .language        (language),
    .operation       (operation),
    .value           (value),
    .current_balance (current_balance),
    .another_service (another_service),
    .timeout         (timeout),
    .balance         (balance),
    .op_done         (op_done),
    .error           (error),
    .start_timer     (start_timer),
    .restart_timer   (restart_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [BW-1:0] e_bal, input logic e_done,
                           input logic e_err, input logic e_st, input logic e_rs,
                           input logic [1:0] e_state);
    check_eq({tag, ".balance"}, 32'(balance), 32'(e_bal));
    check_eq({tag, ".op_done"}, 32'(op_done), 32'(e_done));
    check_eq({tag, ".error"}, 32'(error), 32'(e_err));
    check_eq({tag, ".start_timer"}, 32'(start_timer), 32'(e_st));
    check_eq({tag, ".restart_timer"}, 32'(restart_timer), 32'(e_rs));
    check_eq({tag, ".state"}, 32'(dut.r_state), 32'(e_state));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Insert card and enter a correct PIN: ends with the FSM in MENU.
  task automatic go_menu();
    card_in   = 1'b1;
    wrong_psw = 1'b0;
    tick();
    tick();
  endtask

  task automatic leave();
    card_in         = 1'b0;
    timeout         = 1'b0;
    another_service = 1'b0;
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b0;
    card_in         = 1'b0;
    wrong_psw       = 1'b0;
    language        = 1'b0;
    operation       = 2'b00;
    value           = '0;
    current_balance = '0;
    another_service = 1'b0;
    timeout         = 1'b0;
    tick();
    tick();
    check_out("reset", 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);
    rst = 1'b1;
    tick();

    // Withdraw 100 from 500, full step-by-step session.
    card_in = 1'b1; wrong_psw = 1'b0; language = 1'b1;
    operation = OP_WITHDRAW; value = 20'd100; current_balance = 20'd500;
    tick(); check_out("wd.pw",   20'd0,   1'b0, 1'b0, 1'b1, 1'b0, ST_PASSWORD);
    tick(); check_out("wd.menu", 20'd0,   1'b0, 1'b0, 1'b0, 1'b1, ST_MENU);
    tick(); check_out("wd.exec", 20'd0,   1'b0, 1'b0, 1'b0, 1'b0, ST_EXEC);
    tick(); check_out("wd.done", 20'd400, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE);
    leave(); check_out("wd.hold", 20'd400, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);

    // Deposit overflow, then a small deposit in the same session.
    go_menu();
    operation = OP_DEPOSIT; value = 20'hFFFF5; current_balance = 20'd20; another_service = 1'b1;
    tick(); tick();
    check_out("dep.ovf", 20'd20, 1'b0, 1'b1, 1'b0, 1'b1, ST_MENU);
    value = 20'd5; another_service = 1'b0;
    tick(); tick();
    check_out("dep.ok", 20'd25, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE);
    leave();

    // Withdraw more than the balance, then exactly the balance.
    go_menu();
    operation = OP_WITHDRAW; value = 20'd600; current_balance = 20'd500;
    tick(); tick();
    check_out("wd.over", 20'd500, 1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE);
    leave();
    go_menu();
    value = 20'd500;
    tick(); tick();
    check_out("wd.exact", 20'd0, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE);
    leave();

    // Three wrong PINs.
    card_in = 1'b1; wrong_psw = 1'b1;
    tick();
    tick(); check_out("pin.1", 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_PASSWORD);
    tick(); check_out("pin.2", 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_PASSWORD);
    tick(); check_out("pin.3", 20'd0, 1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE);
    check_eq("pin.attempts", 32'(dut.r_attempts), 32'd0);
    leave();

    // Inquiry with another service, then timeout in MENU.
    go_menu();
    operation = OP_INQUIRY; current_balance = 20'd777; another_service = 1'b1;
    tick(); tick();
    check_out("inq", 20'd777, 1'b1, 1'b0, 1'b0, 1'b1, ST_MENU);
    timeout = 1'b1;
    tick(); check_out("tmo.menu", 20'd777, 1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE);
    leave();

    // Invalid operation code.
    go_menu();
    operation = OP_INVALID; value = 20'd9; current_balance = 20'd777;
    tick(); tick();
    check_out("inv", 20'd777, 1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE);
    leave();

    // Card pulled out in MENU: silent return to IDLE.
    go_menu();
    card_in = 1'b0;
    tick(); check_out("card.out", 20'd777, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);

    // Timeout in PASSWORD outranks a wrong PIN.
    card_in = 1'b1; wrong_psw = 1'b1;
    tick();
    timeout = 1'b1;
    tick(); check_out("tmo.pw", 20'd777, 1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE);
    leave();

    // Asynchronous reset while in EXEC aborts silently.
    go_menu();
    operation = OP_WITHDRAW; value = 20'd1; current_balance = 20'd500;
    tick();
    check_eq("rst.in_exec", 32'(dut.r_state), 32'(ST_EXEC));
    #2 rst = 1'b0;
    #1 check_out("rst.async", 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);
    tick(); check_out("rst.held", 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);
    card_in = 1'b0;
    rst = 1'b1;
    tick(); check_out("rst.after", 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
